stepgen_dir: RTL

Step/direction pulse generator for one LinuxCNC axis. It consumes a signed velocity command and produces step and direction outputs, which are routed to GPIO_1 pins on the DE2 top level. A DDS phase accumulator sets the step rate. A timing FSM enforces step pulse width, step space and direction-setup times. The block also keeps a commanded-position counter for readback.

---
 rtl/stepgen_pkg.sv | 20 ++
 rtl/stepgen_dds.sv | 80 ++++++++
 rtl/stepgen_dir.sv | 129 ++++++++++++
 3 files changed

// File: rtl/stepgen_pkg.sv
// Shared types and default constants for the step/direction generator.
// Timing defaults assume a 50 MHz system clock.
package stepgen_pkg;

  localparam int RATE_W_DEF     = 24;
  localparam int ACC_W_DEF      = 32;
  localparam int POS_W_DEF      = 32;
  localparam int STEP_LEN_DEF   = 250;
  localparam int STEP_SPACE_DEF = 250;
  localparam int DIR_SETUP_DEF  = 100;
  localparam int CNT_W          = 16;

  typedef enum logic [1:0] {
    IDLE,
    DIR_CHG,
    STEP_HI,
    STEP_LO
  } state_e;

endpackage

// File: rtl/stepgen_dds.sv
// Rate register, DDS phase accumulator and the single-entry step request slot.
// A carry is registered, then becomes a pending request on the following edge.
module stepgen_dds
  import stepgen_pkg::*;
#(
  parameter int RATE_W = RATE_W_DEF,
  parameter int ACC_W  = ACC_W_DEF
) (
  input  logic              clk_i,
  input  logic              reset_i,
  input  logic              enable_i,
  input  logic [RATE_W-1:0] rate_cmd_i,
  input  logic              rate_load_i,
  input  logic              take_i,
  input  logic              overrun_clr_i,
  output logic              pending_o,
  output logic              pend_dir_o,
  output logic              overrun_o
);

  localparam logic [RATE_W-1:0] RATE_MIN = {1'b1, {(RATE_W-1){1'b0}}};
  localparam logic [RATE_W-1:0] RATE_MAX = {1'b0, {(RATE_W-1){1'b1}}};

  logic [RATE_W-1:0] rate_q, rate_d;
  logic [RATE_W-1:0] mag;
  logic [ACC_W-1:0]  acc_q, acc_d;
  logic [ACC_W:0]    sum;
  logic              carry_q, carry_d;
  logic              pending_q, pending_d;
  logic              pend_dir_q, pend_dir_d;
  logic              overrun_q, overrun_d;

  always_comb begin
    rate_d = rate_load_i ? rate_cmd_i : rate_q;

    // The most negative rate has no positive twin, so it saturates.
    if (rate_q == RATE_MIN)      mag = RATE_MAX;
    else if (rate_q[RATE_W-1])   mag = -rate_q;
    else                         mag = rate_q;

    sum     = {1'b0, acc_q} + (ACC_W+1)'(mag);
    acc_d   = enable_i ? sum[ACC_W-1:0] : '0;
    carry_d = enable_i & sum[ACC_W];

    pending_d  = take_i ? 1'b0 : pending_q;
    pend_dir_d = pend_dir_q;
    overrun_d  = overrun_clr_i ? 1'b0 : overrun_q;
    if (carry_q) begin
      if (pending_q) begin
        overrun_d = 1'b1;
      end else begin
        pending_d  = 1'b1;
        pend_dir_d = rate_q[RATE_W-1];
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      rate_q     <= '0;
      acc_q      <= '0;
      carry_q    <= 1'b0;
      pending_q  <= 1'b0;
      pend_dir_q <= 1'b0;
      overrun_q  <= 1'b0;
    end else begin
      rate_q     <= rate_d;
      acc_q      <= acc_d;
      carry_q    <= carry_d;
      pending_q  <= pending_d;
      pend_dir_q <= pend_dir_d;
      overrun_q  <= overrun_d;
    end
  end

  assign pending_o  = pending_q;
  assign pend_dir_o = pend_dir_q;
  assign overrun_o  = overrun_q;

endmodule

// File: rtl/stepgen_dir.sv
// Step/direction generator top: pulse timing FSM and commanded-position counter.
// Each timed state loads N-1 on entry and lasts exactly N clocks.
module stepgen_dir
  import stepgen_pkg::*;
#(
  parameter int RATE_W     = RATE_W_DEF,
  parameter int ACC_W      = ACC_W_DEF,
  parameter int POS_W      = POS_W_DEF,
  parameter int STEP_LEN   = STEP_LEN_DEF,
  parameter int STEP_SPACE = STEP_SPACE_DEF,
  parameter int DIR_SETUP  = DIR_SETUP_DEF
) (
  input  logic              CLOCK_50,
  input  logic              reset,
  input  logic              enable,
  input  logic [RATE_W-1:0] rate_cmd,
  input  logic              rate_load,
  input  logic              pos_clr,
  input  logic              overrun_clr,
  output logic              step_out,
  output logic              dir_out,
  output logic              busy,
  output logic [POS_W-1:0]  position,
  output logic              overrun,
  output state_e            state_dbg_o
);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             step_q, step_d;
  logic             dir_q, dir_d;
  logic [POS_W-1:0] pos_q, pos_d;
  logic             issue;
  logic             take;
  logic             pending;
  logic             pend_dir;

  stepgen_dds #(
    .RATE_W (RATE_W),
    .ACC_W  (ACC_W)
  ) u_dds (
    .clk_i         (CLOCK_50),
    .reset_i       (reset),
    .enable_i      (enable),
    .rate_cmd_i    (rate_cmd),
    .rate_load_i   (rate_load),
    .take_i        (take),
    .overrun_clr_i (overrun_clr),
    .pending_o     (pending),
    .pend_dir_o    (pend_dir),
    .overrun_o     (overrun)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    step_d  = step_q;
    dir_d   = dir_q;
    pos_d   = pos_q;
    issue   = 1'b0;
    take    = 1'b0;

    case (state_q)
      IDLE: begin
        if (pending) begin
          if (pend_dir != dir_q) begin
            dir_d   = pend_dir;
            state_d = DIR_CHG;
            cnt_d   = CNT_W'(DIR_SETUP - 1);
          end else begin
            issue = 1'b1;
          end
        end
      end
      DIR_CHG: begin
        if (cnt_q == '0) issue = 1'b1;
        else             cnt_d = cnt_q - 1'b1;
      end
      STEP_HI: begin
        if (cnt_q == '0) begin
          state_d = STEP_LO;
          step_d  = 1'b0;
          cnt_d   = CNT_W'(STEP_SPACE - 1);
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      STEP_LO: begin
        if (cnt_q == '0) state_d = IDLE;
        else             cnt_d   = cnt_q - 1'b1;
      end
      default: state_d = IDLE;
    endcase

    if (issue) begin
      state_d = STEP_HI;
      cnt_d   = CNT_W'(STEP_LEN - 1);
      step_d  = 1'b1;
      take    = 1'b1;
      pos_d   = pend_dir ? pos_q - POS_W'(1) : pos_q + POS_W'(1);
    end

    // A clear overrides a same-cycle step count.
    if (pos_clr) pos_d = '0;
  end

  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      step_q  <= 1'b0;
      dir_q   <= 1'b0;
      pos_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      step_q  <= step_d;
      dir_q   <= dir_d;
      pos_q   <= pos_d;
    end
  end

  assign step_out    = step_q;
  assign dir_out     = dir_q;
  assign busy        = (state_q != IDLE);
  assign position    = pos_q;
  assign state_dbg_o = state_q;

endmodule
